// File: rtl/counting_gen.sv
// counting_gen: sends COUNT x (01,10,11) on num with a detector mirror; GAP_INSERT_EN adds GAP idle 00 symbols between repetitions
module counting_gen #(
  parameter int CNT_W = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             ready,
  output logic [1:0]       num,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             exp_ans
);
  typedef enum logic [2:0] {IDLE, SEND1, SEND2, SEND3, GAP_ST, DONE} state_t;
  typedef enum logic [1:0] {M0, M1, M2, M3} mir_t;
  state_t state_q, state_d, rep_next;
  mir_t mir_q, mir_d;
  logic [CNT_W-1:0] cnt_q;
  logic last_rep, gap_last;
  assign last_rep = (sent_cnt + CNT_W'(1)) == cnt_q;
`ifdef GAP_INSERT_EN
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  logic [GW-1:0] gap_q;
  assign gap_last = gap_q == GW'(GAP - 1);
  assign rep_next = GAP > 0 ? GAP_ST : SEND1;
  always_ff @(posedge clk or posedge reset)
    if (reset) gap_q <= '0;
    else gap_q <= state_q == GAP_ST ? gap_q + GW'(1) : '0;
`else
  logic [31:0] unused_gap;
  assign unused_gap = GAP;
  assign gap_last = 1'b1;
  assign rep_next = SEND1;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (count == '0 ? DONE : SEND1) : IDLE;
      SEND1:   state_d = ready ? SEND2 : SEND1;
      SEND2:   state_d = ready ? SEND3 : SEND2;
      SEND3:   state_d = ready ? (last_rep ? DONE : rep_next) : SEND3;
      GAP_ST:  state_d = gap_last ? SEND1 : GAP_ST;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Detector copy: tracks every driven symbol, including held ones and 00 fillers
  always_comb begin
    mir_d = mir_q;
    case (mir_q)
      M0:      mir_d = num == 2'b01 ? M1 : M0;
      M1:      mir_d = num == 2'b10 ? M2 : num == 2'b11 ? M0 : M1;
      M2:      mir_d = num == 2'b01 ? M1 : num == 2'b11 ? M3 : M2;
      default: mir_d = num == 2'b01 ? M1 : num == 2'b10 ? M0 : M3;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      mir_q    <= M0;
      cnt_q    <= '0;
      sent_cnt <= '0;
    end else begin
      state_q <= state_d;
      mir_q   <= mir_d;
      if (state_q == IDLE && start) begin
        cnt_q    <= count;
        sent_cnt <= '0;
      end else if (state_q == SEND3 && ready) sent_cnt <= sent_cnt + CNT_W'(1);
    end
  assign num     = state_q == SEND1 ? 2'b01 : state_q == SEND2 ? 2'b10 : state_q == SEND3 ? 2'b11 : 2'b00;
  assign valid   = state_q inside {SEND1, SEND2, SEND3};
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign exp_ans = mir_q == M3;
endmodule

// File: tb/tb_counting_gen.sv
// tb_counting_gen: scoreboard bench for counting_gen; accepted symbols are compared against queued expectations
module tb_counting_gen;
  localparam int CW = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ready = 1'b1;
  logic [CW-1:0] count = '0;
  logic [1:0] num;
  logic valid, busy, done, exp_ans;
  logic [CW-1:0] sent_cnt;
  int checks = 0, errors = 0;
  logic [1:0] sb[$];
  logic [1:0] sb_exp;
  logic [1:0] pat[3] = '{2'b01, 2'b10, 2'b11};

  counting_gen #(.CNT_W(CW), .GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .ready(ready),
    .num(num), .valid(valid), .busy(busy), .done(done), .sent_cnt(sent_cnt), .exp_ans(exp_ans)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && valid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected symbol num=%b", num);
      end else begin
        sb_exp = sb.pop_front();
        if (num !== sb_exp) begin
          errors++;
          $display("FAIL scoreboard: num=%b expected %b", num, sb_exp);
        end
      end
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n);
    for (int r = 0; r < n; r++) begin
      sb.push_back(2'b01);
      sb.push_back(2'b10);
      sb.push_back(2'b11);
    end
    count = CW'(n);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int c = 0;
    while (done !== 1'b1 && c < bound) begin
      tick;
      c++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, expected 1", done, c);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({num, valid, busy, done, exp_ans, sent_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_values: got %h expected 0", {num, valid, busy, done, exp_ans, sent_cnt});
    end
    #5 reset = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic;
    launch(3);
`ifdef GAP_INSERT_EN
    wait_done(100);
`else
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (num !== pat[i % 3] || valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_sym%0d: num=%b valid=%b done=%b expected num=%b valid=1 done=0", i, num, valid, done, pat[i % 3]);
      end
      checks++;
      if (exp_ans !== (i == 3 || i == 6)) begin
        errors++;
        $display("FAIL basic_ans%0d: exp_ans=%b expected %b", i, exp_ans, (i == 3 || i == 6));
      end
      tick;
    end
`endif
    checks++;
    if (done !== 1'b1 || exp_ans !== 1'b1 || sent_cnt !== 8'd3 || valid !== 1'b0 || num !== 2'b00) begin
      errors++;
      $display("FAIL basic_done: done=%b exp_ans=%b sent_cnt=%0d valid=%b num=%b expected 1 1 3 0 00", done, exp_ans, sent_cnt, valid, num);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sent_cnt !== 8'd3 || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b sent_cnt=%0d pending=%0d expected 0 0 3 0", done, busy, sent_cnt, sb.size());
    end
  endtask

  task automatic test_zero;
    launch(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || valid !== 1'b0 || sent_cnt !== 8'd0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b valid=%b sent_cnt=%0d expected 1 1 0 0", done, busy, valid, sent_cnt);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: done=%b busy=%b valid=%b expected 0 0 0", done, busy, valid);
    end
  endtask

  task automatic test_stall;
    launch(1);
    checks++;
    if (num !== 2'b01 || exp_ans !== 1'b1) begin
      errors++;
      $display("FAIL stall_first: num=%b exp_ans=%b expected 01 1", num, exp_ans);
    end
    tick;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (num !== 2'b10 || valid !== 1'b1 || exp_ans !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: num=%b valid=%b exp_ans=%b expected 10 1 0", i, num, valid, exp_ans);
      end
    end
    ready = 1'b1;
    tick;
    checks++;
    if (num !== 2'b11 || exp_ans !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume: num=%b exp_ans=%b expected 11 0", num, exp_ans);
    end
    tick;
    checks++;
    if (done !== 1'b1 || exp_ans !== 1'b1 || sent_cnt !== 8'd1) begin
      errors++;
      $display("FAIL stall_done: done=%b exp_ans=%b sent_cnt=%0d expected 1 1 1", done, exp_ans, sent_cnt);
    end
    tick;
  endtask

  task automatic test_ignore;
    launch(2);
    tick;
    tick;
    start = 1'b1;
    count = 8'd5;
    tick;
    start = 1'b0;
    count = 8'd0;
    wait_done(50);
    checks++;
    if (sent_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ignore_cnt: sent_cnt=%0d expected 2", sent_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL ignore_idle%0d: busy=%b valid=%b expected 0 0", i, busy, valid);
      end
    end
  endtask

  task automatic test_async_reset;
    int c = 0;
    launch(2);
    while (!(num === 2'b10 && sent_cnt === 8'd1) && c < 20) begin
      tick;
      c++;
    end
    checks++;
    if (c >= 20) begin
      errors++;
      $display("FAIL areset_reach: num=%b sent_cnt=%0d, expected to reach 10 with sent_cnt 1", num, sent_cnt);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({num, valid, busy, done, exp_ans, sent_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL areset_values: got %h expected 0", {num, valid, busy, done, exp_ans, sent_cnt});
    end
    sb.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_idle: busy=%b expected 0", busy);
    end
    launch(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (num !== pat[i]) begin
        errors++;
        $display("FAIL areset_sym%0d: num=%b expected %b", i, num, pat[i]);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || sent_cnt !== 8'd1) begin
      errors++;
      $display("FAIL areset_done: done=%b sent_cnt=%0d expected 1 1", done, sent_cnt);
    end
    tick;
  endtask

  task automatic test_max;
    launch(255);
    wait_done(2000);
    checks++;
    if (sent_cnt !== 8'd255 || sb.size() != 0) begin
      errors++;
      $display("FAIL max_cnt: sent_cnt=%0d pending=%0d expected 255 0", sent_cnt, sb.size());
    end
    tick;
  endtask

`ifdef GAP_INSERT_EN
  task automatic test_gap;
    logic [1:0] gseq[8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    launch(2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (num !== gseq[i] || done !== 1'b0) begin
        errors++;
        $display("FAIL gap_sym%0d: num=%b done=%b expected %b 0", i, num, done, gseq[i]);
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (exp_ans !== 1'b1 || busy !== 1'b1 || valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_fill%0d: exp_ans=%b busy=%b valid=%b expected 1 1 0", i, exp_ans, busy, valid);
        end
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || exp_ans !== 1'b1 || sent_cnt !== 8'd2) begin
      errors++;
      $display("FAIL gap_done: done=%b exp_ans=%b sent_cnt=%0d expected 1 1 2", done, exp_ans, sent_cnt);
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_stall;
    test_ignore;
    test_async_reset;
    test_max;
`ifdef GAP_INSERT_EN
    test_gap;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
